sequenciador_varredura: RTL and testbench

Scan sequencer driving the channel index and enable of the 3-to-8 one-hot decoder stage directly downstream. On a start pulse it steps through the channels selected by an 8-bit mask, holding each for a programmable dwell time. It either makes a single pass or repeats continuously until a stop request. Its `A`/`E` outputs connect to the decoder's address and enable inputs.

---
 rtl/sequenciador_varredura.sv | 152 +++++++++++++++
 tb/tb_sequenciador_varredura.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sequenciador_varredura.sv
// Channel scan sequencer: walks the set bits of a latched mask, holding each channel
// for dwell+1 cycles, and drives the address/enable of a 3-to-8 one-hot decoder.
module sequenciador_varredura #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               continuous,
  output logic [2:0]         A,
  output logic               E,
  output logic               busy,
  output logic               done
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [2:0]         a_q, a_d;
  logic               e_q, e_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               stop_pend_q, stop_pend_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               cont_q;

  logic               slot_end;
  logic [2:0]         nxt_ch;
  logic               wrap;

  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    logic [2:0] r;
    logic       found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && !found) begin
        r     = 3'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Circular search starting just above cur; offset 8 folds back onto cur itself,
  // so a single-channel mask reselects the same channel.
  function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic [2:0] idx;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = cur + 3'(i);
      if (m[idx] && !found) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign slot_end = (cnt_q == dwell_q);
  assign nxt_ch   = next_ch(mask_q, a_q);
  assign wrap     = (nxt_ch <= a_q);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    e_d         = e_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    stop_pend_d = stop_pend_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mask == 8'h00) begin
            done_d = 1'b1;
          end else begin
            state_d = S_ACTIVE;
            a_d     = lowest_ch(mask);
            e_d     = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        stop_pend_d = stop_pend_q | stop;
        if (slot_end) begin
          // A stop arriving in the slot-end cycle itself still ends the scan here.
          if (stop_pend_q || stop || (wrap && !cont_q)) begin
            state_d     = S_IDLE;
            a_d         = '0;
            e_d         = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
            cnt_d       = '0;
          end else begin
            a_d   = nxt_ch;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      e_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      e_q         <= e_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      cnt_q       <= cnt_d;
    end
  end

  // Scan configuration is captured only when a start is accepted.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      mask_q  <= mask;
      dwell_q <= dwell;
      cont_q  <= continuous;
    end
  end

  assign A    = a_q;
  assign E    = e_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sequenciador_varredura.sv
// Directed, table-driven bench for sequenciador_varredura with a behavioural
// 3-to-8 decoder hung off A/E.
module tb_sequenciador_varredura;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, continuous;
  logic [7:0] mask;
  logic [7:0] dwell;
  logic [2:0] A;
  logic       E, busy, done;
  logic [7:0] S;

  always #5 clk = ~clk;

  sequenciador_varredura #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mask(mask),
    .dwell(dwell), .continuous(continuous), .A(A), .E(E), .busy(busy), .done(done)
  );

  assign S = E ? (8'h01 << A) : 8'h00;

  typedef struct {
    logic       st;
    logic       sp;
    logic [7:0] m;
    logic [7:0] d;
    logic       c;
    logic [2:0] a;
    logic       e;
    logic       b;
    logic       dn;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s #%0d got %h expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic [7:0] m, input logic [7:0] d,
                     input logic c, input logic [2:0] a, input logic e, input logic b,
                     input logic dn);
    vec_t v;
    v.st = st; v.sp = sp; v.m = m; v.d = d; v.c = c;
    v.a = a; v.e = e; v.b = b; v.dn = dn;
    vq.push_back(v);
  endtask

  // Mid-scan filler: deliberately noisy config inputs that must be ignored.
  task automatic act(input logic [2:0] a);
    add(1'b0, 1'b0, 8'h5A, 8'h07, 1'b1, a, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic fin();
    add(1'b0, 1'b0, 8'h5A, 8'h07, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic quiet();
    add(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] es;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    mask = 8'h00; dwell = 8'h00; continuous = 1'b0;
    #12;
    chk("reset_out", 0, {2'b0, A, E, busy, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single pass over all channels, 3-cycle slots
    add(1'b1, 1'b0, 8'hFF, 8'd2, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 24; k++) act(3'(k / 3));
    fin();
    quiet();

    // Continuous 2,5,7 with a mid-scan start/mask change, then stop on a 1-cycle slot
    add(1'b1, 1'b0, 8'hA4, 8'd0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
    act(3'd5); act(3'd7); act(3'd2);
    add(1'b1, 1'b0, 8'hFF, 8'd9, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0);
    act(3'd7); act(3'd2); act(3'd5);
    add(1'b0, 1'b1, 8'h5A, 8'h07, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    quiet();

    // Stop in the 2nd cycle of channel 5: slot completes, channel 7 never shows
    add(1'b1, 1'b0, 8'hA4, 8'd3, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
    act(3'd2); act(3'd2); act(3'd2);
    act(3'd5); act(3'd5);
    add(1'b0, 1'b1, 8'h5A, 8'h07, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0);
    act(3'd5);
    fin();
    quiet();

    // Empty mask, then back-to-back start during the done cycle
    add(1'b1, 1'b0, 8'h00, 8'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 8'h80, 8'd0, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0);
    fin();
    quiet();

    // Single channel, continuous: A stays 4
    add(1'b1, 1'b0, 8'h10, 8'd1, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) act(3'd4);
    add(1'b0, 1'b1, 8'h5A, 8'h07, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0);
    fin();
    quiet();

    // Stop alone in IDLE is ignored; start+stop in IDLE starts normally
    add(1'b0, 1'b1, 8'hFF, 8'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'h03, 8'd0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    act(3'd1); act(3'd0);
    add(1'b0, 1'b1, 8'h5A, 8'h07, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    quiet();

    // Maximum dwell: 256-cycle slots
    add(1'b1, 1'b0, 8'h03, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 256; k++) act(3'd0);
    for (int k = 0; k < 256; k++) act(3'd1);
    fin();
    quiet();

    foreach (vq[i]) begin
      start = vq[i].st; stop = vq[i].sp; mask = vq[i].m;
      dwell = vq[i].d; continuous = vq[i].c;
      tick();
      chk("A", i, {5'b0, A}, {5'b0, vq[i].a});
      chk("E_busy_done", i, {5'b0, E, busy, done}, {5'b0, vq[i].e, vq[i].b, vq[i].dn});
      es = 8'h00;
      if (vq[i].e) es[vq[i].a] = 1'b1;
      chk("decoder_S", i, S, es);
    end

    // Asynchronous reset mid-slot with A=5
    start = 1'b1; stop = 1'b0; mask = 8'h20; dwell = 8'd10; continuous = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_reset_A", 0, {5'b0, A, E}, {5'b0, 3'd5, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 0, {2'b0, A, E, busy, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_reset_idle", k, {2'b0, A, E, busy, done}, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
